// File: rtl/register_tree_pkg.sv
// Shared op encoding and timing constants for the register-tree priority queue.
package register_tree_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ENQ  = 2'd0,
    OP_DEQ  = 2'd1,
    OP_REPL = 2'd2,
    OP_NOP  = 2'd3
  } op_t;

  // One sweep needs at most one wait plus one cycle per level; two per level is safe.
  function automatic int settle_cycles(input int levels);
    return 2 * levels;
  endfunction

endpackage

// File: rtl/register_tree_cas.sv
// Three-way compare-and-swap for one parent and its two children.
// Entries are {valid, key, payload}; an invalid entry loses every comparison.
module register_tree_cas
  import register_tree_pkg::*;
#(
  parameter int KEY_W    = 16,
  parameter int PAY_W    = 8,
  parameter int MIN_MODE = 0,
  localparam int ENT_W   = 1 + KEY_W + PAY_W
) (
  input  logic [ENT_W-1:0] parent,
  input  logic [ENT_W-1:0] left,
  input  logic [ENT_W-1:0] right,
  output logic [ENT_W-1:0] new_parent,
  output logic [ENT_W-1:0] new_left,
  output logic [ENT_W-1:0] new_right
);

  logic             pv, lv, rv, bv;
  logic [KEY_W-1:0] pk, lk, rk, bk;
  logic             right_wins, child_wins;
  logic [ENT_W-1:0] best;

  function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
    logic res;
    if (MIN_MODE != 0) res = (a < b);
    else               res = (a > b);
    return res;
  endfunction

  assign pv = parent[ENT_W-1];
  assign lv = left[ENT_W-1];
  assign rv = right[ENT_W-1];
  assign pk = parent[ENT_W-2 -: KEY_W];
  assign lk = left[ENT_W-2 -: KEY_W];
  assign rk = right[ENT_W-2 -: KEY_W];

  // Strict comparisons: equal children favour the left, an equal parent stays put.
  assign right_wins = rv && (!lv || better(rk, lk));
  assign best       = right_wins ? right : left;
  assign bv         = best[ENT_W-1];
  assign bk         = best[ENT_W-2 -: KEY_W];
  assign child_wins = bv && (!pv || better(bk, pk));

  always_comb begin
    new_parent = parent;
    new_left   = left;
    new_right  = right;
    if (child_wins) begin
      new_parent = best;
      if (right_wins) new_right = parent;
      else            new_left  = parent;
    end
  end

endmodule

// File: rtl/register_tree_kv.sv
// Register binary-heap priority queue with {key, payload} entries, kept ordered by
// an odd/even-level systolic compare-and-swap network.
module register_tree_kv
  import register_tree_pkg::*;
#(
  parameter int LEVELS   = 5,
  parameter int KEY_W    = 16,
  parameter int PAY_W    = 8,
  parameter int MIN_MODE = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_valid,
  input  logic [OP_W-1:0]   i_op,
  input  logic [KEY_W-1:0]  i_key,
  input  logic [PAY_W-1:0]  i_payload,
  output logic              o_ready,
  output logic              o_top_valid,
  output logic [KEY_W-1:0]  o_top_key,
  output logic [PAY_W-1:0]  o_top_payload,
  output logic [LEVELS-1:0] o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_err
);

  localparam int N      = (1 << LEVELS) - 1;
  localparam int NP     = (N - 1) / 2;
  localparam int ENT_W  = 1 + KEY_W + PAY_W;
  localparam int SETTLE = settle_cycles(LEVELS);
  localparam int SW     = $clog2(SETTLE + 1);

  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] key;
    logic [PAY_W-1:0] payload;
  } node_t;

  node_t             node [N];
  logic [LEVELS-1:0] count;
  logic              phase;
  logic [SW-1:0]     settle;
  logic              err;

  logic [ENT_W-1:0]  cas_p [NP];
  logic [ENT_W-1:0]  cas_l [NP];
  logic [ENT_W-1:0]  cas_r [NP];
  logic [NP-1:0]     cas_act;

  op_t   op;
  node_t entry;
  logic  full, empty, accept, is_err, do_write;

  // Handshake: an op is taken on any edge where i_valid && o_ready; o_ready stays low
  // for the settle window after a state-changing op, and inputs are ignored meanwhile.
  assign op       = op_t'(i_op);
  assign entry    = {1'b1, i_key, i_payload};
  assign full     = (count == N[LEVELS-1:0]);
  assign empty    = (count == '0);
  assign accept   = i_valid && o_ready;
  assign is_err   = ((op == OP_ENQ) && full) || ((op == OP_DEQ) && empty);
  assign do_write = accept && (op != OP_NOP) && !is_err;

  for (genvar p = 0; p < NP; p++) begin : g_cas
    localparam int LVL = $clog2(p + 2) - 1;
    assign cas_act[p] = (phase == ((LVL % 2) == 1));
    register_tree_cas #(
      .KEY_W    (KEY_W),
      .PAY_W    (PAY_W),
      .MIN_MODE (MIN_MODE)
    ) u_cas (
      .parent     (node[p]),
      .left       (node[2*p+1]),
      .right      (node[2*p+2]),
      .new_parent (cas_p[p]),
      .new_left   (cas_l[p]),
      .new_right  (cas_r[p])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) node[i] <= '0;
      count  <= '0;
      phase  <= 1'b0;
      settle <= '0;
      err    <= 1'b0;
    end else begin
      phase <= ~phase;
      err   <= accept && is_err;
      if (settle != '0) settle <= settle - 1'b1;

      if (do_write) begin
        settle <= SW'(SETTLE);
        case (op)
          OP_ENQ: begin
            node[count] <= entry;
            count       <= count + 1'b1;
          end
          OP_DEQ: begin
            // With one entry both writes hit the root and the invalidation wins.
            node[0]              <= node[count - 1'b1];
            node[count - 1'b1]   <= '0;
            count                <= count - 1'b1;
          end
          OP_REPL: begin
            node[0] <= entry;
            if (empty) count <= count + 1'b1;
          end
          default: ;
        endcase
      end else begin
        // Active parents sit on alternate levels, so no node is written twice.
        for (int p = 0; p < NP; p++) begin
          if (cas_act[p]) begin
            node[p]     <= cas_p[p];
            node[2*p+1] <= cas_l[p];
            node[2*p+2] <= cas_r[p];
          end
        end
      end
    end
  end

  assign o_ready       = (settle == '0);
  assign o_top_valid   = node[0].valid;
  assign o_top_key     = node[0].key;
  assign o_top_payload = node[0].payload;
  assign o_count       = count;
  assign o_full        = full;
  assign o_empty       = empty;
  assign o_err         = err;

endmodule

// File: tb/tb_register_tree_kv.sv
// Bench for register_tree_kv: a max-mode and a min-mode instance share one op stream
// and are checked against per-mode multiset models plus a table of hand-derived vectors.
module tb_register_tree_kv;

  localparam int LEVELS = 3;
  localparam int N      = 7;
  localparam int SETTLE = 6;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       i_valid = 1'b0;
  logic [1:0] i_op = 2'd3;
  logic [7:0] i_key = '0;
  logic [7:0] i_payload = '0;

  logic [1:0]      rdy, tv, f_o, e_o, err_o;
  logic [1:0][7:0] tk, tp;
  logic [1:0][2:0] cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] q_max[$];
  logic [15:0] q_min[$];

  typedef struct {
    bit         rst;
    logic [1:0] op;
    logic [7:0] key;
    logic [7:0] exp_max;
    logic [7:0] exp_min;
    int         exp_cnt;
    bit         exp_err;
  } vec_t;
  vec_t vt[$];

  register_tree_kv #(.LEVELS(LEVELS), .KEY_W(8), .PAY_W(8), .MIN_MODE(0)) u_max (
    .CLK(CLK), .RST(RST), .i_valid(i_valid), .i_op(i_op), .i_key(i_key),
    .i_payload(i_payload), .o_ready(rdy[0]), .o_top_valid(tv[0]), .o_top_key(tk[0]),
    .o_top_payload(tp[0]), .o_count(cnt[0]), .o_full(f_o[0]), .o_empty(e_o[0]),
    .o_err(err_o[0])
  );

  register_tree_kv #(.LEVELS(LEVELS), .KEY_W(8), .PAY_W(8), .MIN_MODE(1)) u_min (
    .CLK(CLK), .RST(RST), .i_valid(i_valid), .i_op(i_op), .i_key(i_key),
    .i_payload(i_payload), .o_ready(rdy[1]), .o_top_valid(tv[1]), .o_top_key(tk[1]),
    .o_top_payload(tp[1]), .o_count(cnt[1]), .o_full(f_o[1]), .o_empty(e_o[1]),
    .o_err(err_o[1])
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] qget(input int m, input int i);
    return (m == 0) ? q_max[i] : q_min[i];
  endfunction

  function automatic int best_idx(input int m);
    int b, sz;
    logic [15:0] vi, vb;
    b  = 0;
    sz = (m == 0) ? q_max.size() : q_min.size();
    for (int i = 1; i < sz; i++) begin
      vi = qget(m, i);
      vb = qget(m, b);
      if ((m == 0) ? (vi[15:8] > vb[15:8]) : (vi[15:8] < vb[15:8])) b = i;
    end
    return b;
  endfunction

  function automatic logic [15:0] exp_top(input int m);
    if (q_max.size() == 0) return 16'h0;
    return qget(m, best_idx(m));
  endfunction

  // Reference model: each mode holds an unordered multiset of {key, payload}.
  task automatic model_step(input logic [1:0] op, input logic [7:0] k, input logic [7:0] p,
                            output bit e, output bit r);
    int sz;
    sz = q_max.size();
    e  = 1'b0;
    r  = 1'b0;
    case (op)
      2'd0: if (sz == N) e = 1'b1;
            else begin q_max.push_back({k, p}); q_min.push_back({k, p}); r = 1'b1; end
      2'd1: if (sz == 0) e = 1'b1;
            else begin q_max.delete(best_idx(0)); q_min.delete(best_idx(1)); r = 1'b1; end
      2'd2: begin
        if (sz != 0) begin q_max.delete(best_idx(0)); q_min.delete(best_idx(1)); end
        q_max.push_back({k, p});
        q_min.push_back({k, p});
        r = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic check_state(input string tag);
    logic [15:0] t;
    for (int m = 0; m < 2; m++) begin
      t = exp_top(m);
      chk($sformatf("%s m%0d top_valid", tag, m), tv[m], q_max.size() != 0);
      chk($sformatf("%s m%0d top_key", tag, m), tk[m], t[15:8]);
      chk($sformatf("%s m%0d top_payload", tag, m), tp[m], t[7:0]);
      chk($sformatf("%s m%0d count", tag, m), cnt[m], q_max.size());
      chk($sformatf("%s m%0d full", tag, m), f_o[m], q_max.size() == N);
      chk($sformatf("%s m%0d empty", tag, m), e_o[m], q_max.size() == 0);
    end
  endtask

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic do_reset();
    @(negedge CLK);
    RST     = 1'b1;
    i_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    q_max.delete();
    q_min.delete();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(rdy[0] && rdy[1]) && n < 100) begin
      n++;
      @(negedge CLK);
    end
    if (!(rdy[0] && rdy[1])) chk("ready_timeout", rdy, 2'b11);
  endtask

  task automatic do_op(input logic [1:0] op, input logic [7:0] k, input logic [7:0] p,
                       output bit got_err);
    bit e, r;
    int lo;
    wait_ready();
    i_valid   = 1'b1;
    i_op      = op;
    i_key     = k;
    i_payload = p;
    model_step(op, k, p, e, r);
    @(negedge CLK);
    // Junk on the bus while not valid must be ignored.
    i_valid   = 1'b0;
    i_op      = 2'd0;
    i_key     = 8'($urandom);
    i_payload = 8'($urandom);
    got_err   = err_o[0];
    chk("err m0", err_o[0], e);
    chk("err m1", err_o[1], e);
    chk("count_next m0", cnt[0], q_max.size());
    chk("count_next m1", cnt[1], q_max.size());
    lo = 0;
    while (!rdy[0] && lo < 40) begin
      lo++;
      @(negedge CLK);
    end
    chk("ready_low_cycles", lo, r ? SETTLE : 0);
    if (e) begin
      @(negedge CLK);
      chk("err_pulse_end", err_o, 2'b00);
    end
    check_state("post_op");
  endtask

  task automatic add(input bit rs, input logic [1:0] op, input logic [7:0] k,
                     input logic [7:0] mx, input logic [7:0] mn, input int c, input bit er);
    vec_t v;
    v.rst = rs; v.op = op; v.key = k; v.exp_max = mx; v.exp_min = mn;
    v.exp_cnt = c; v.exp_err = er;
    vt.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ge;
    logic [7:0] xp;

    // Reset state.
    do_reset();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("reset m%0d ready", m), rdy[m], 1);
      chk($sformatf("reset m%0d empty", m), e_o[m], 1);
      chk($sformatf("reset m%0d full", m), f_o[m], 0);
      chk($sformatf("reset m%0d count", m), cnt[m], 0);
      chk($sformatf("reset m%0d top_key", m), tk[m], 0);
      chk($sformatf("reset m%0d top_valid", m), tv[m], 0);
      chk($sformatf("reset m%0d err", m), err_o[m], 0);
    end

    // Vector table: {reset first, op, key, max top, min top, count, err}; payload = key+1.
    add(1, 2'd0,   5,  5,  5, 1, 0);
    add(0, 2'd0,   9,  9,  5, 2, 0);
    add(0, 2'd0,   3,  9,  3, 3, 0);
    add(0, 2'd1,   0,  5,  5, 2, 0);
    add(1, 2'd0,  10, 10, 10, 1, 0);
    add(0, 2'd0,  20, 20, 10, 2, 0);
    add(0, 2'd0,  30, 30, 10, 3, 0);
    add(0, 2'd0,  40, 40, 10, 4, 0);
    add(0, 2'd0,  50, 50, 10, 5, 0);
    add(0, 2'd0,  60, 60, 10, 6, 0);
    add(0, 2'd0,  70, 70, 10, 7, 0);
    add(0, 2'd0, 100, 70, 10, 7, 1);
    add(1, 2'd0,   4,  4,  4, 1, 0);
    add(0, 2'd0,   8,  8,  4, 2, 0);
    add(0, 2'd0,   8,  8,  4, 3, 0);
    add(0, 2'd0,   1,  8,  1, 4, 0);
    add(0, 2'd1,   0,  8,  4, 3, 0);
    add(0, 2'd1,   0,  4,  8, 2, 0);
    add(0, 2'd1,   0,  1,  8, 1, 0);
    add(0, 2'd1,   0,  0,  0, 0, 0);
    add(0, 2'd1,   0,  0,  0, 0, 1);
    add(1, 2'd0,  10, 10, 10, 1, 0);
    add(0, 2'd0,   6, 10,  6, 2, 0);
    add(0, 2'd0,   2, 10,  2, 3, 0);
    add(0, 2'd2,   1,  6,  1, 3, 0);
    add(1, 2'd2,   7,  7,  7, 1, 0);
    add(0, 2'd3,  99,  7,  7, 1, 0);

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      do_op(vt[i].op, vt[i].key, vt[i].key + 8'd1, ge);
      chk($sformatf("vec%0d max_key", i), tk[0], vt[i].exp_max);
      xp = (vt[i].exp_cnt == 0) ? 8'd0 : vt[i].exp_max + 8'd1;
      chk($sformatf("vec%0d max_payload", i), tp[0], xp);
      chk($sformatf("vec%0d min_key", i), tk[1], vt[i].exp_min);
      xp = (vt[i].exp_cnt == 0) ? 8'd0 : vt[i].exp_min + 8'd1;
      chk($sformatf("vec%0d min_payload", i), tp[1], xp);
      chk($sformatf("vec%0d count", i), cnt[0], vt[i].exp_cnt);
      chk($sformatf("vec%0d err", i), ge, vt[i].exp_err);
    end

    // Reset asserted in the second settle cycle of an ENQ discards everything.
    do_reset();
    do_op(2'd0, 8'd40, 8'd41, ge);
    wait_ready();
    i_valid   = 1'b1;
    i_op      = 2'd0;
    i_key     = 8'd5;
    i_payload = 8'd6;
    @(negedge CLK);
    i_valid = 1'b0;
    chk("mid_rst settling", rdy, 2'b00);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    q_max.delete();
    q_min.delete();
    chk("mid_rst ready", rdy, 2'b11);
    chk("mid_rst empty", e_o, 2'b11);
    chk("mid_rst err", err_o, 2'b00);
    check_state("mid_rst");

    // Random ops, issued as soon as o_ready returns; payload is a function of key.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      int sel;
      logic [1:0] op;
      logic [7:0] k;
      sel = $urandom_range(0, 9);
      op  = (sel < 4) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      k   = 8'($urandom_range(0, 255));
      do_op(op, k, k ^ 8'hA5, ge);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
